// File: rtl/ls_unit_pkg.sv
// Shared constants for the load/store buffer, ROB and load/store unit:
// opcode encoding, ROB tag width and the common zero values.
package ls_unit_pkg;
  localparam int OPENUM_W = 3;
  localparam int ROB_ID_W = 4;

  // All load opcodes encode at or below OP_LHU.
  typedef enum logic [OPENUM_W-1:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } openum_e;

  localparam logic [ROB_ID_W-1:0] ZERO_ROB  = '0;
  localparam logic [31:0]         ZERO_WORD = '0;

  function automatic logic is_load(openum_e op);
    return op <= OP_LHU;
  endfunction

  // Index of the final byte of an access (byte count minus one).
  function automatic logic [1:0] last_idx(openum_e op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction
endpackage

// File: rtl/ls_unit_if.sv
// Load/store unit bus bundle: LSB request, byte-wide memory port and CDB result.
interface ls_unit_if;
  import ls_unit_pkg::*;

  logic                rdy;
  logic                enable_signal_from_lsb;
  openum_e             openum_from_lsb;
  logic [31:0]         mem_address_from_lsb;
  logic [31:0]         stored_data_from_lsb;
  logic [ROB_ID_W-1:0] rob_id_from_lsb;
  logic                rollback_signal;
  logic                busy_signal_to_lsb;
  logic                mem_req;
  logic [31:0]         mem_addr;
  logic                mem_wr;
  logic [7:0]          mem_wdata;
  logic                mem_ready;
  logic [7:0]          mem_rdata;
  logic                valid_signal;
  logic [ROB_ID_W-1:0] rob_id_out;
  logic [31:0]         result_out;

  modport slave (
    input  rdy, enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
           stored_data_from_lsb, rob_id_from_lsb, rollback_signal, mem_ready, mem_rdata,
    output busy_signal_to_lsb, mem_req, mem_addr, mem_wr, mem_wdata,
           valid_signal, rob_id_out, result_out
  );

  modport master (
    output rdy, enable_signal_from_lsb, openum_from_lsb, mem_address_from_lsb,
           stored_data_from_lsb, rob_id_from_lsb, rollback_signal, mem_ready, mem_rdata,
    input  busy_signal_to_lsb, mem_req, mem_addr, mem_wr, mem_wdata,
           valid_signal, rob_id_out, result_out
  );
endinterface

// File: rtl/ls_unit.sv
// Load/store unit: serialises one LSB request into byte accesses on the memory
// port and broadcasts extended load results on the CDB.
module ls_unit
  import ls_unit_pkg::*;
(
  input logic     clk,
  input logic     rst,
  ls_unit_if.slave bus
);
  typedef enum logic {IDLE, ACCESS} state_e;

  state_e              state;
  openum_e             op_q;
  logic [31:0]         addr_q;
  logic [31:0]         data_q;
  logic [31:0]         buf_q;
  logic [ROB_ID_W-1:0] rob_q;
  logic [1:0]          cnt;
  logic [31:0]         merged;
  logic                last;
  logic                load_q;

  function automatic logic [31:0] extend(openum_e op, logic [31:0] w);
    case (op)
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      OP_LBU:  return {24'd0, w[7:0]};
      OP_LHU:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign load_q = is_load(op_q);
  assign last   = (cnt == last_idx(op_q));

  // Address and write byte derive from the latched request, so they stay
  // stable for as long as the controller keeps us waiting.
  assign bus.mem_addr           = addr_q + 32'(cnt);
  assign bus.mem_wdata          = data_q[{cnt, 3'b000} +: 8];
  assign bus.busy_signal_to_lsb = (state != IDLE);

  always_comb begin
    merged = buf_q;
    merged[{cnt, 3'b000} +: 8] = bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      op_q             <= OP_LB;
      addr_q           <= ZERO_WORD;
      data_q           <= ZERO_WORD;
      buf_q            <= ZERO_WORD;
      rob_q            <= ZERO_ROB;
      cnt              <= 2'd0;
      bus.mem_req      <= 1'b0;
      bus.mem_wr       <= 1'b0;
      bus.valid_signal <= 1'b0;
      bus.rob_id_out   <= ZERO_ROB;
      bus.result_out   <= ZERO_WORD;
    end else if (bus.rdy) begin
      bus.valid_signal <= 1'b0;
      unique case (state)
        IDLE: begin
          // A load arriving with a flush is already squashed; stores are committed.
          if (bus.enable_signal_from_lsb &&
              !(bus.rollback_signal && is_load(bus.openum_from_lsb))) begin
            state       <= ACCESS;
            op_q        <= bus.openum_from_lsb;
            addr_q      <= bus.mem_address_from_lsb;
            data_q      <= bus.stored_data_from_lsb;
            rob_q       <= bus.rob_id_from_lsb;
            buf_q       <= ZERO_WORD;
            cnt         <= 2'd0;
            bus.mem_req <= 1'b1;
            bus.mem_wr  <= !is_load(bus.openum_from_lsb);
          end
        end
        ACCESS: begin
          if (bus.rollback_signal && load_q) begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
          end else if (bus.mem_ready) begin
            buf_q <= merged;
            cnt   <= cnt + 2'd1;
            if (last) begin
              state       <= IDLE;
              bus.mem_req <= 1'b0;
              if (load_q) begin
                bus.valid_signal <= 1'b1;
                bus.rob_id_out   <= rob_q;
                bus.result_out   <= extend(op_q, merged);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: a driver owns all inputs and acts as the memory responder,
// a scoreboard of expected CDB results is drained by an independent monitor.
module tb_ls_unit;
  import ls_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  ls_unit_if bus();

  ls_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [ROB_ID_W-1:0] rob;
    logic [31:0]         res;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] mem [logic [31:0]];
  bit         stall_en = 0;
  bit         gap_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int nbytes(input openum_e op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit is_ld(input openum_e op);
    return (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
  endfunction

  // Reference load: little-endian word from memory, then two's-complement extension.
  function automatic logic [31:0] ref_load(input openum_e op, input logic [31:0] a);
    logic [31:0] w = 32'd0;
    for (int i = 0; i < nbytes(op); i++) w = w + (32'(rd(a + 32'(i))) << (8 * i));
    if (op == OP_LB && w >= 32'd128)   w = w - 32'd256;
    if (op == OP_LH && w >= 32'd32768) w = w - 32'd65536;
    return w;
  endfunction

  function automatic logic pick_rdy();
    return stall_en ? ($urandom_range(0, 7) != 0) : 1'b1;
  endfunction

  function automatic int pick_wait(input int wfix);
    return (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
  endfunction

  // Every CDB broadcast the rest of the core would consume must match the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rdy && bus.valid_signal) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL cdb_unexpected: got rob %0d result %h, expected no broadcast",
                 bus.rob_id_out, bus.result_out);
      end else begin
        e = sb.pop_front();
        chk("cdb_rob", 32'(bus.rob_id_out), 32'(e.rob));
        chk("cdb_result", bus.result_out, e.res);
      end
    end
  end

  task automatic run_txn(input openum_e op, input logic [31:0] a, input logic [31:0] d,
                         input logic [ROB_ID_W-1:0] rob, input int rb_at, input int wfix,
                         input bit rb_en, input bit chk_lat, input int rst_at,
                         input bit have_want, input logic [31:0] want);
    int   n       = nbytes(op);
    bit   ld      = is_ld(op);
    int   k       = 0;
    int   edges   = 0;
    int   w;
    int   guard   = 0;
    int   rb_left = rb_at;
    bit   dropped = 0;
    bit   hit_rst = 0;
    bit   rb;
    logic [7:0] wd;

    bus.enable_signal_from_lsb = 1'b1;
    bus.openum_from_lsb        = op;
    bus.mem_address_from_lsb   = a;
    bus.stored_data_from_lsb   = d;
    bus.rob_id_from_lsb        = rob;
    bus.rollback_signal        = rb_en;
    forever begin
      bus.rdy       = pick_rdy();
      bus.mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("req_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
      @(posedge clk); #1;
      if (bus.rdy) break;
      if (++guard > 200) begin
        $display("FAIL accept_timeout: got no accept cycle, expected one within 200");
        n_chk++; n_fail++;
        break;
      end
    end
    bus.enable_signal_from_lsb = 1'b0;
    bus.rollback_signal        = 1'b0;
    if (rb_en && ld) dropped = 1;
    if (ld && !dropped && rb_at < 0) sb.push_back('{rob: rob, res: ref_load(op, a)});

    w = pick_wait(wfix);
    guard = 0;
    while (!dropped && k < n) begin
      rb            = (rb_left == k);
      bus.rdy       = (rst_at == k) ? 1'b0 : pick_rdy();
      bus.mem_ready = (w == 0);
      bus.mem_rdata = rd(bus.mem_addr);
      bus.rollback_signal = rb;
      rst           = (rst_at == k);
      @(negedge clk);
      chk("acc_busy", 32'(bus.busy_signal_to_lsb), 32'd1);
      chk("acc_mem_req", 32'(bus.mem_req), 32'd1);
      chk("acc_mem_addr", bus.mem_addr, a + 32'(k));
      chk("acc_mem_wr", 32'(bus.mem_wr), 32'(!ld));
      if (!ld) chk("acc_mem_wdata", 32'(bus.mem_wdata), 32'(d[8*k +: 8]));
      wd = bus.mem_wdata;
      @(posedge clk); #1;
      edges++;
      if (rst) begin hit_rst = 1; break; end
      if (bus.rdy) begin
        if (rb && ld) begin dropped = 1; break; end
        if (rb) rb_left = -1;
        if (w == 0) begin
          if (!ld) mem[a + 32'(k)] = wd;
          k++;
          w = pick_wait(wfix);
        end else w--;
      end
      if (++guard > 500) begin
        $display("FAIL access_timeout: got %0d bytes done, expected %0d", k, n);
        n_chk++; n_fail++;
        break;
      end
    end

    bus.rollback_signal = 1'b0;
    bus.mem_ready       = 1'($urandom_range(0, 1));
    bus.rdy             = pick_rdy();
    rst                 = 1'b0;
    @(negedge clk);
    if (hit_rst) begin
      chk("rst_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_valid", 32'(bus.valid_signal), 32'd0);
      chk("rst_rob_id", 32'(bus.rob_id_out), 32'(ZERO_ROB));
      chk("rst_result", bus.result_out, 32'd0);
    end else begin
      chk("done_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
      chk("done_mem_req", 32'(bus.mem_req), 32'd0);
      chk("done_valid", 32'(bus.valid_signal), 32'(ld && !dropped));
      if (ld && !dropped && chk_lat) chk("latency", 32'(edges + 1), 32'(n * (wfix + 1) + 1));
      if (ld && !dropped && have_want) chk("want_result", bus.result_out, want);
    end
    @(posedge clk); #1;
    if (gap_en) begin
      repeat ($urandom_range(0, 2)) begin
        bus.rdy       = pick_rdy();
        bus.mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    openum_e     op;
    logic [31:0] a;
    int          rba;

    rst = 1'b1;
    bus.rdy = 1'b1;
    bus.enable_signal_from_lsb = 1'b1;
    bus.openum_from_lsb = OP_LW;
    bus.mem_address_from_lsb = 32'h1234;
    bus.stored_data_from_lsb = 32'hFFFF_FFFF;
    bus.rob_id_from_lsb = 4'd5;
    bus.rollback_signal = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("init_busy", 32'(bus.busy_signal_to_lsb), 32'd0);
    chk("init_mem_req", 32'(bus.mem_req), 32'd0);
    chk("init_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("init_mem_addr", bus.mem_addr, 32'd0);
    chk("init_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("init_valid", 32'(bus.valid_signal), 32'd0);
    chk("init_rob_id", 32'(bus.rob_id_out), 32'(ZERO_ROB));
    chk("init_result", bus.result_out, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.enable_signal_from_lsb = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios with no stalls, so latency is exact.
    mem[32'h200] = 8'h80;
    run_txn(OP_LB, 32'h200, 32'h0, 4'd3, -1, 0, 0, 1, -1, 1, 32'hFFFF_FF80);
    mem[32'h10] = 8'h34; mem[32'h11] = 8'h12;
    run_txn(OP_LHU, 32'h10, 32'h0, 4'd4, -1, 0, 0, 1, -1, 1, 32'h0000_1234);
    mem[32'h20] = 8'hFF; mem[32'h21] = 8'h80;
    run_txn(OP_LH, 32'h20, 32'h0, 4'd6, -1, 0, 0, 1, -1, 1, 32'hFFFF_80FF);
    run_txn(OP_SW, 32'h100, 32'hDEAD_BEEF, 4'd7, -1, 0, 0, 0, -1, 0, 32'h0);
    chk("sw_byte0", 32'(rd(32'h100)), 32'hEF);
    chk("sw_byte1", 32'(rd(32'h101)), 32'hBE);
    chk("sw_byte2", 32'(rd(32'h102)), 32'hAD);
    chk("sw_byte3", 32'(rd(32'h103)), 32'hDE);
    run_txn(OP_LW, 32'h100, 32'h0, 4'd8, -1, 2, 0, 1, -1, 1, 32'hDEAD_BEEF);
    run_txn(OP_LW, 32'h300, 32'h0, 4'd9, 2, 0, 0, 0, -1, 0, 32'h0);
    run_txn(OP_SB, 32'h400, 32'h0000_00C3, 4'd10, -1, 0, 0, 0, -1, 0, 32'h0);
    chk("sb_after_rb", 32'(rd(32'h400)), 32'hC3);
    run_txn(OP_LB, 32'h500, 32'h0, 4'd11, -1, 0, 1, 0, -1, 0, 32'h0);
    run_txn(OP_SB, 32'h501, 32'h0000_005E, 4'd12, -1, 0, 1, 0, -1, 0, 32'h0);
    chk("sb_with_rb_en", 32'(rd(32'h501)), 32'h5E);
    run_txn(OP_SH, 32'h600, 32'h0000_A55A, 4'd13, 1, 1, 0, 0, -1, 0, 32'h0);
    chk("sh_rb_byte1", 32'(rd(32'h601)), 32'hA5);
    run_txn(OP_LW, 32'hFFFF_FFFE, 32'h0, 4'd14, -1, 0, 0, 1, -1, 0, 32'h0);
    run_txn(OP_LW, 32'h700, 32'h0, 4'd1, -1, 0, 0, 1, -1, 0, 32'h0);
    run_txn(OP_SH, 32'h800, 32'h0000_7788, 4'd2, -1, 0, 0, 0, 1, 0, 32'h0);

    // Randomised traffic with rdy stalls, wait states, gaps and flushes.
    stall_en = 1;
    gap_en   = 1;
    for (int t = 0; t < 300; t++) begin
      op  = openum_e'($urandom_range(0, 7));
      a   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                        : 32'($urandom_range(0, 255));
      rba = (is_ld(op) && $urandom_range(0, 9) == 0) ? int'($urandom_range(0, nbytes(op) - 1)) : -1;
      run_txn(op, a, $urandom, ROB_ID_W'($urandom_range(1, (1 << ROB_ID_W) - 1)), rba, -1,
              ($urandom_range(0, 15) == 0), 0, -1, 0, 32'h0);
    end

    bus.rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
